// File: rtl/upscale_pkg.sv
// Shared constants and state encoding for the 30x40 -> 240x320 binary frame upscaler.
package upscale_pkg;

  localparam int IN_W      = 40;
  localparam int IN_H      = 30;
  localparam int SHIFT     = 3;
  localparam int OUT_W     = IN_W << SHIFT;
  localparam int OUT_H     = IN_H << SHIFT;
  localparam int ROW_IDX_W = 8;
  localparam int WR_CNT_W  = $clog2(IN_H);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

endpackage

// File: rtl/frame_upscaler_row_replicator.sv
// Nearest-neighbour horizontal expansion: each source pixel becomes 2**SHIFT adjacent output pixels.
module row_replicator #(
  parameter int SRC_W = 40,
  parameter int SHIFT = 3
) (
  input  logic [SRC_W-1:0]            src_row,
  output logic [(SRC_W<<SHIFT)-1:0]   wide_row
);

  for (genvar b = 0; b < (SRC_W << SHIFT); b++) begin : g_rep
    assign wide_row[b] = src_row[b >> SHIFT];
  end

endmodule

// File: rtl/frame_upscaler.sv
// Stores a 30x40 binary frame, then streams it back as 240 rows of 320 pixels with valid/ready flow control.
module frame_upscaler
  import upscale_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 row_valid_in,
  input  logic [IN_W-1:0]      row_in,
  output logic                 in_ready_out,
  output logic                 row_valid_out,
  input  logic                 row_ready_in,
  output logic [OUT_W-1:0]     row_out,
  output logic [ROW_IDX_W-1:0] row_index_out,
  output logic                 frame_done_out
);

  // Handshake: an output row transfers on a rising edge where row_valid_out and
  // row_ready_in are both high; while valid is high and ready low, row_out and
  // row_index_out hold. Input rows transfer whenever row_valid_in and in_ready_out are high.

  logic [IN_W-1:0]            mem [IN_H];
  state_t                     state;
  logic [WR_CNT_W-1:0]        wr_cnt;
  logic [ROW_IDX_W-1:0]       rd_cnt;
  logic [ROW_IDX_W-SHIFT-1:0] rd_addr;
  logic [OUT_W-1:0]           expanded;
  logic                       wr_en;
  logic                       wr_last;
  logic                       out_fire;
  logic                       last_fire;
  logic                       load;

  assign in_ready_out = (state == COLLECT);
  assign wr_en        = in_ready_out && row_valid_in;
  assign wr_last      = wr_en && (wr_cnt == WR_CNT_W'(IN_H - 1));
  assign out_fire     = row_valid_out && row_ready_in;
  assign last_fire    = out_fire && (row_index_out == ROW_IDX_W'(OUT_H - 1));
  assign load         = (state == EMIT) && (!row_valid_out || row_ready_in) &&
                        (rd_cnt < ROW_IDX_W'(OUT_H)) && !last_fire;

  // Every 2**SHIFT output rows reuse one stored input row.
  assign rd_addr = rd_cnt[ROW_IDX_W-1:SHIFT];

  row_replicator #(
    .SRC_W (IN_W),
    .SHIFT (SHIFT)
  ) u_row_replicator (
    .src_row  (mem[rd_addr]),
    .wide_row (expanded)
  );

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_cnt] <= row_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state          <= COLLECT;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      row_valid_out  <= 1'b0;
      row_out        <= '0;
      row_index_out  <= '0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      case (state)
        COLLECT: begin
          if (wr_en) begin
            if (wr_last) begin
              wr_cnt <= '0;
              rd_cnt <= '0;
              state  <= EMIT;
            end else begin
              wr_cnt <= wr_cnt + WR_CNT_W'(1);
            end
          end
        end
        EMIT: begin
          if (last_fire) begin
            row_valid_out  <= 1'b0;
            frame_done_out <= 1'b1;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            state          <= COLLECT;
          end else if (load) begin
            row_out       <= expanded;
            row_index_out <= rd_cnt;
            row_valid_out <= 1'b1;
            rd_cnt        <= rd_cnt + ROW_IDX_W'(1);
          end else if (out_fire) begin
            row_valid_out <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
